// File: rtl/red_bbox.sv
// Red-pixel bounding box accumulator: qualifies horizontal red runs of at least
// MIN_RUN pixels, tracks the box and count per frame, and publishes on the next sop.
module red_bbox #(
  parameter int MIN_RUN    = 4,
  parameter int MIN_PIXELS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sop,
  input  logic        in_valid,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        red_sector,
  input  logic        out_ready,
  output logic        bbox_valid,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [10:0] y_min,
  output logic [10:0] y_max,
  output logic [19:0] pixel_count,
  output logic        detected,
  output logic        overrun
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [3:0]  RUN_MAX  = 4'(MIN_RUN);
  localparam logic [10:0] RUN_BACK = 11'(MIN_RUN - 1);
  localparam logic [10:0] MIN_INIT = 11'd2047;
  localparam logic [19:0] CNT_MAX  = 20'hFFFFF;

  state_t      state_q, state_d;
  logic [3:0]  run_q, run_d;
  logic [10:0] prev_y_q, prev_y_d;
  logic [10:0] acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [10:0] acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic [19:0] acc_cnt_q, acc_cnt_d;
  logic        latch_q, latch_d;
  logic        bbox_valid_q, bbox_valid_d;
  logic [10:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [10:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic [19:0] cnt_q, cnt_d;
  logic        det_q, det_d;
  logic        overrun_q, overrun_d;

  logic        pixel, first, cont, hit, empty;
  logic [3:0]  run_inc, add;
  logic [10:0] lo_x;
  logic [10:0] b_xmin, b_xmax, b_ymin, b_ymax;
  logic [19:0] b_cnt;
  logic [20:0] sum;

  always_comb begin
    pixel   = in_valid && !sop && (state_q == ACCUM);
    first   = (x == 11'd0) || (y != prev_y_q);
    run_inc = first ? 4'd1 : ((run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1);
    cont    = !first && (run_q == RUN_MAX);
    hit     = pixel && red_sector && (cont || (run_inc == RUN_MAX));
    add     = cont ? 4'd1 : RUN_MAX;
    lo_x    = cont ? x : ((x >= RUN_BACK) ? x - RUN_BACK : 11'd0);

    // The latch edge starts the new frame, so a pixel in that cycle builds on init values
    b_xmin = latch_q ? MIN_INIT : acc_xmin_q;
    b_xmax = latch_q ? 11'd0    : acc_xmax_q;
    b_ymin = latch_q ? MIN_INIT : acc_ymin_q;
    b_ymax = latch_q ? 11'd0    : acc_ymax_q;
    b_cnt  = latch_q ? 20'd0    : acc_cnt_q;
    sum    = {1'b0, b_cnt} + {17'd0, add};

    state_d    = sop ? ACCUM : state_q;
    latch_d    = sop && (state_q == ACCUM);
    prev_y_d   = pixel ? y : prev_y_q;
    run_d      = run_q;
    if (sop)        run_d = 4'd0;
    else if (pixel) run_d = red_sector ? run_inc : 4'd0;

    acc_xmin_d = b_xmin;
    acc_xmax_d = b_xmax;
    acc_ymin_d = b_ymin;
    acc_ymax_d = b_ymax;
    acc_cnt_d  = b_cnt;
    if (hit) begin
      acc_xmin_d = (lo_x < b_xmin) ? lo_x : b_xmin;
      acc_xmax_d = (x > b_xmax) ? x : b_xmax;
      acc_ymin_d = (y < b_ymin) ? y : b_ymin;
      acc_ymax_d = (y > b_ymax) ? y : b_ymax;
      acc_cnt_d  = sum[20] ? CNT_MAX : sum[19:0];
    end

    empty        = (acc_cnt_q == 20'd0);
    bbox_valid_d = bbox_valid_q;
    x_min_d      = x_min_q;
    x_max_d      = x_max_q;
    y_min_d      = y_min_q;
    y_max_d      = y_max_q;
    cnt_d        = cnt_q;
    det_d        = det_q;
    overrun_d    = overrun_q;
    if (latch_q) begin
      bbox_valid_d = 1'b1;
      x_min_d      = empty ? 11'd0 : acc_xmin_q;
      x_max_d      = empty ? 11'd0 : acc_xmax_q;
      y_min_d      = empty ? 11'd0 : acc_ymin_q;
      y_max_d      = empty ? 11'd0 : acc_ymax_q;
      cnt_d        = acc_cnt_q;
      det_d        = {12'd0, acc_cnt_q} >= 32'(MIN_PIXELS);
      if (bbox_valid_q && !out_ready) overrun_d = 1'b1;
    end else if (bbox_valid_q && out_ready) begin
      bbox_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      run_q        <= 4'd0;
      prev_y_q     <= 11'd0;
      acc_xmin_q   <= MIN_INIT;
      acc_xmax_q   <= 11'd0;
      acc_ymin_q   <= MIN_INIT;
      acc_ymax_q   <= 11'd0;
      acc_cnt_q    <= 20'd0;
      latch_q      <= 1'b0;
      bbox_valid_q <= 1'b0;
      x_min_q      <= 11'd0;
      x_max_q      <= 11'd0;
      y_min_q      <= 11'd0;
      y_max_q      <= 11'd0;
      cnt_q        <= 20'd0;
      det_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      prev_y_q     <= prev_y_d;
      acc_xmin_q   <= acc_xmin_d;
      acc_xmax_q   <= acc_xmax_d;
      acc_ymin_q   <= acc_ymin_d;
      acc_ymax_q   <= acc_ymax_d;
      acc_cnt_q    <= acc_cnt_d;
      latch_q      <= latch_d;
      bbox_valid_q <= bbox_valid_d;
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
      cnt_q        <= cnt_d;
      det_q        <= det_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bbox_valid  = bbox_valid_q;
  assign x_min       = x_min_q;
  assign x_max       = x_max_q;
  assign y_min       = y_min_q;
  assign y_max       = y_max_q;
  assign pixel_count = cnt_q;
  assign detected    = det_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/red_bbox.md
RED_BBOX -- requirements
Module: red_bbox

Interface
REQ-001 SHALL have parameter MIN_RUN, default 4, meaning the number of consecutive red pixels on a row needed before any of them count (range 1..15).
REQ-002 SHALL have parameter MIN_PIXELS, default 64, meaning the minimum qualified pixel count for a frame to report detected=1.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all state.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sop, input, 1 bit: frame start marker; a cycle with sop=1 is never a pixel.
REQ-006 SHALL have port in_valid, input, 1 bit: pixel strobe.
REQ-007 SHALL have port x, input, 11 bits: column of the current pixel.
REQ-008 SHALL have port y, input, 11 bits: row of the current pixel.
REQ-009 SHALL have port red_sector, input, 1 bit: per-pixel red classification from the HSV stage, same-cycle as x/y.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port bbox_valid, output, 1 bit: result available.
REQ-012 SHALL have ports x_min, x_max, y_min and y_max, each output, 11 bits: box of the last completed frame.
REQ-013 SHALL have port pixel_count, output, 20 bits: qualified red pixels in that frame.
REQ-014 SHALL have port detected, output, 1 bit: pixel_count >= MIN_PIXELS.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag, set when an unaccepted result is overwritten.

Function
REQ-016 SHALL treat a pixel as a cycle with in_valid=1 and sop=0; all other cycles leave accumulators unchanged.
REQ-017 SHALL implement FSM IDLE -> ACCUM on the first sop after reset, and stay in ACCUM thereafter; in IDLE pixels are ignored.
REQ-018 SHALL keep a 4-bit run counter, cleared on sop, on any pixel with x==0 whose red_sector=0, on any pixel with red_sector=0, and on a change of y between consecutive pixels.
REQ-019 SHALL, on a red pixel, set run = (x==0 or y changed) ? 1 : run+1, saturating at MIN_RUN.
REQ-020 SHALL, on the pixel where run first reaches MIN_RUN, add MIN_RUN to the count and merge column x-(MIN_RUN-1) and column x into the box; on each further red pixel of the run, add 1 and merge x.
REQ-021 SHALL merge as x_min=min, x_max=max, y_min=min, y_max=max; accumulators SHALL start at x_min=y_min=2047 and x_max=y_max=0, with count=0, and SHALL saturate count at 2^20-1.
REQ-022 SHALL, on sop while in ACCUM, copy the accumulators to the output registers one cycle later, then set bbox_valid=1 and reinitialise the accumulators in the same edge.
REQ-023 SHALL output all box fields as 0 when the frame count is 0, rather than the 2047/0 sentinels.
REQ-024 SHALL compute detected = (count >= MIN_PIXELS) at latch time.
REQ-025 SHALL clear bbox_valid on a cycle with bbox_valid=1 and out_ready=1, unless a new latch occurs in the same cycle, in which case bbox_valid stays 1 with the new data.
REQ-026 SHALL hold output fields stable while bbox_valid=1 and no new latch occurs.
REQ-027 SHALL, when a latch occurs while bbox_valid=1 and out_ready=0, overwrite the outputs and set overrun=1; overrun clears only on reset.
REQ-028 SHALL, on sop in the same cycle as in_valid, apply the sop behaviour only, so that the pixel is dropped.
REQ-029 SHALL end the last frame only on a subsequent sop and never on a timeout.

Reset
REQ-030 SHALL, while reset_n=0, force FSM=IDLE, run=0, accumulators to their init values, bbox_valid=0, all output fields 0, detected=0 and overrun=0, independent of clk.
REQ-031 SHALL, on reset asserted mid-frame, discard the partial frame; after release no result appears until two sops have been seen.

Verification
REQ-032 SHALL cover this scenario: sop; a row y=100 with red at x=200..209, MIN_RUN=4; sop -> bbox_valid=1, x_min=200, x_max=209, y_min=y_max=100, pixel_count=10, detected=0.
REQ-033 SHALL cover this scenario: sop; red at x=50..52 only (run 3 < 4); sop -> pixel_count=0, all box fields 0, detected=0.
REQ-034 SHALL cover this scenario: a 10x10 red block at x=300..309, y=40..49; sop -> box (300,309,40,49), count=100, detected=1.
REQ-035 SHALL cover this scenario: two frames complete with out_ready=0 -> second result visible, overrun=1; then out_ready=1 for one cycle -> bbox_valid=0.
REQ-036 SHALL cover this scenario: reset_n pulsed low mid-frame after 20 red pixels; sop; an empty frame; sop -> pixel_count=0, overrun=0.
REQ-037 SHALL cover this scenario: red run x=637..639 on row 5 continuing x=0 on row 6 with MIN_RUN=4 -> no pixels counted.
